instr_fetch: RTL and testbench

Sequential instruction-fetch unit for the single-cycle core. It owns the program counter and the Start/Ack run handshake, and drives the instruction-ROM address whose output feeds the control decoder. It consumes the decoder's `branch`, `how_high` and halt indications plus the ALU condition flag to select the next PC. The two-bit `how_high` index selects a signed relative jump offset from a small lookup table.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/branch_lut.sv | 23 ++
 rtl/instr_fetch.sv | 79 +++++++
 tb/tb_instr_fetch.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM states, default PC width
// and the relative-branch offset table consumed by branch_lut.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam int PCW_DEFAULT = 10;

  // Branch offsets indexed by how_high; the decoder team edits only these.
  localparam logic signed [PCW_DEFAULT-1:0] LUT_OFS0 = PCW_DEFAULT'(-3);
  localparam logic signed [PCW_DEFAULT-1:0] LUT_OFS1 = PCW_DEFAULT'(5);
  localparam logic signed [PCW_DEFAULT-1:0] LUT_OFS2 = PCW_DEFAULT'(-12);
  localparam logic signed [PCW_DEFAULT-1:0] LUT_OFS3 = PCW_DEFAULT'(20);

endpackage

// File: rtl/branch_lut.sv
// Combinational how_high -> signed relative branch offset, resized to the PC width.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int W = PCW_DEFAULT
) (
  input  logic [1:0]          idx,
  output logic signed [W-1:0] offset
);

  // Signed source in a size cast sign-extends when W exceeds the table width.
  always_comb begin
    offset = W'(LUT_OFS0);
    unique case (idx)
      2'd0: offset = W'(LUT_OFS0);
      2'd1: offset = W'(LUT_OFS1);
      2'd2: offset = W'(LUT_OFS2);
      2'd3: offset = W'(LUT_OFS3);
      default: offset = W'(LUT_OFS0);
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Program counter, Start/Ack run handshake and next-PC selection for the
// single-cycle core. All outputs come straight from flops.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PCW = PCW_DEFAULT
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           Branch,
  input  logic           Taken,
  input  logic [1:0]     how_high,
  input  logic           Halt,
  output logic [PCW-1:0] prog_ctr,
  output logic           Ack,
  output logic           running
);

  fetch_state_e          state_q, state_d;
  logic [PCW-1:0]        pc_q, pc_d;
  logic                  ack_q, ack_d;
  logic                  running_q, running_d;
  logic signed [PCW-1:0] br_ofs;

  branch_lut #(.W(PCW)) u_lut (
    .idx    (how_high),
    .offset (br_ofs)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) state_d = RUN;
      end
      RUN: begin
        // Halt wins over a simultaneous taken branch so Ack reports the halt address.
        if (Halt)                 state_d = DONE;
        else if (Branch && Taken) pc_d = pc_q + $unsigned(br_ofs);
        else                      pc_d = pc_q + PCW'(1);
      end
      DONE: begin
        if (Start) begin
          state_d = IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
    // Status flags are registered copies of the next state, so no input reaches them combinationally.
    ack_d     = (state_d == DONE);
    running_d = (state_d == RUN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ack_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ack_q     <= ack_d;
      running_q <= running_d;
    end
  end

  assign prog_ctr = pc_q;
  assign Ack      = ack_q;
  assign running  = running_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: each stimulus cycle queues its hand-computed
// outcome, and a monitor compares it just after the following rising edge.
module tb_instr_fetch;
  localparam int PCW = 10;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1, Start = 1'b0, Branch = 1'b0, Taken = 1'b0, Halt = 1'b0;
  logic [1:0]     how_high = 2'd0;
  logic [PCW-1:0] prog_ctr;
  logic           Ack, running;

  instr_fetch #(.PCW(PCW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .Taken(Taken),
    .how_high(how_high), .Halt(Halt), .prog_ctr(prog_ctr), .Ack(Ack), .running(running)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int             id;
    logic [PCW-1:0] pc;
    logic           ack;
    logic           run;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   step_id = 0;

  // Monitor: the DUT presents a new registered result after every rising edge.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_total++;
      if (prog_ctr === e.pc && Ack === e.ack && running === e.run) n_pass++;
      else $display("FAIL step%0d: got pc=%0d ack=%b run=%b, want pc=%0d ack=%b run=%b",
                    e.id, prog_ctr, Ack, running, e.pc, e.ack, e.run);
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic br, input logic tk,
                     input logic [1:0] hh, input logic hlt,
                     input int epc, input logic eack, input logic erun);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Start = st; Branch = br; Taken = tk; how_high = hh; Halt = hlt;
    e.id = step_id; e.pc = PCW'(epc); e.ack = eack; e.run = erun;
    exp_q.push_back(e);
    step_id++;
  endtask

  // Plain RUN increment, optionally with Start asserted (must be ignored).
  task automatic inc(input int epc, input logic st = 1'b0);
    cyc(1'b0, st, 1'b0, 1'b0, 2'd0, 1'b0, epc, 1'b0, 1'b1);
  endtask

  task automatic br_taken(input logic [1:0] hh, input int epc);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, hh, 1'b0, epc, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset for two cycles, then a one-cycle Start pulse.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) inc(i, (i == 5));

    // Offset table walk.
    br_taken(2'd1, 15);
    br_taken(2'd0, 12);
    br_taken(2'd2, 0);
    br_taken(2'd3, 20);
    cyc(0, 0, 1, 0, 3, 0, 21, 0, 1);

    // Wrap-around in both directions.
    br_taken(2'd2, 9);
    br_taken(2'd2, 1021);
    inc(1022);
    inc(1023);
    inc(0);
    inc(1);
    inc(2);
    br_taken(2'd2, 1014);
    for (int p = 1015; p <= 1020; p++) inc(p);
    br_taken(2'd3, 16);

    // Reach PC 7, then Halt together with a taken branch.
    br_taken(2'd0, 13);
    br_taken(2'd0, 10);
    br_taken(2'd0, 7);
    cyc(0, 0, 1, 1, 1, 1, 7, 1, 0);
    cyc(0, 0, 1, 1, 3, 1, 7, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
    inc(1);
    inc(2);
    inc(3);

    // Reset mid-run at PC 33 with a taken branch presented.
    br_taken(2'd3, 23);
    for (int p = 24; p <= 33; p++) inc(p);
    cyc(1, 0, 1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
    inc(1);

    @(negedge Clk);
    Start = 1'b0; Branch = 1'b0; Taken = 1'b0; Halt = 1'b0;
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge Clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
